// File: rtl/pc_sequencer_pkg.sv
// Shared CPU constants and the PC sequencer state encoding.
package pc_sequencer_pkg;

  localparam int unsigned CPU_ADDR_W = 24;
  localparam int unsigned CPU_CNT_W  = 16;

  typedef enum logic [1:0] {
    PCS_RUN    = 2'b00,
    PCS_HALTED = 2'b01,
    PCS_STEP   = 2'b10
  } pcs_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter stage: registers the next-PC mux output, provides PC+1, and
// gates PC update / commit with a RUN/HALTED/STEP debug state machine.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned          ADDR_W    = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
  parameter int unsigned          CNT_W     = CPU_CNT_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] NextPC,
  input  logic              Halt,
  input  logic              RunReq,
  input  logic              StepReq,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus1,
  output logic              Commit,
  output logic              Running,
  output logic [CNT_W-1:0]  InstrCount
);

  pcs_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              retire_s;

  // An instruction retires only while executing and not sitting on a HALT opcode.
  assign retire_s   = ((state_q == PCS_RUN) || (state_q == PCS_STEP)) && !Halt;

  assign PC         = pc_q;
  assign PCPlus1    = pc_q + ADDR_W'(1);
  assign Commit     = retire_s;
  assign Running    = (state_q != PCS_HALTED);
  assign InstrCount = cnt_q;

  // Next-state, next-PC and retired-count logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (retire_s) begin
      pc_d  = NextPC;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
    end
    case (state_q)
      PCS_RUN: begin
        if (Halt) begin
          state_d = PCS_HALTED;
        end else begin
          state_d = PCS_RUN;
        end
      end
      PCS_HALTED: begin
        // RunReq takes priority when both debug requests arrive together.
        if (RunReq) begin
          state_d = PCS_RUN;
        end else if (StepReq) begin
          state_d = PCS_STEP;
        end else begin
          state_d = PCS_HALTED;
        end
      end
      PCS_STEP: begin
        state_d = PCS_HALTED;
      end
      default: begin
        state_d = PCS_HALTED;
      end
    endcase
  end

  // State, PC and counter registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= PCS_RUN;
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with RESET_VEC = 0x000100.
module tb_pc_sequencer;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned CNT_W  = 16;

  logic              Clock;
  logic              Reset;
  logic [ADDR_W-1:0] NextPC;
  logic              Halt;
  logic              RunReq;
  logic              StepReq;
  logic [ADDR_W-1:0] PC;
  logic [ADDR_W-1:0] PCPlus1;
  logic              Commit;
  logic              Running;
  logic [CNT_W-1:0]  InstrCount;

  int n_checks;
  int n_errors;

  pc_sequencer #(
    .ADDR_W   (ADDR_W),
    .RESET_VEC(24'h000100),
    .CNT_W    (CNT_W)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .NextPC    (NextPC),
    .Halt      (Halt),
    .RunReq    (RunReq),
    .StepReq   (StepReq),
    .PC        (PC),
    .PCPlus1   (PCPlus1),
    .Commit    (Commit),
    .Running   (Running),
    .InstrCount(InstrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_pc;
    n_checks = 0;
    n_errors = 0;
    Reset   = 1'b1;
    NextPC  = 24'h000000;
    Halt    = 1'b0;
    RunReq  = 1'b0;
    StepReq = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("rst_pc",      32'(PC),         32'h000100);
    check("rst_cnt",     32'(InstrCount), 32'h0);
    check("rst_running", 32'(Running),    32'h1);
    check("rst_pcplus1", 32'(PCPlus1),    32'h000101);
    Reset = 1'b0;

    // Run a few cycles, then assert reset asynchronously mid-cycle.
    exp_pc = 24'h000100;
    for (int i = 0; i < 3; i++) begin
      NextPC = exp_pc + 24'h000001;
      tick();
      exp_pc = exp_pc + 24'h000001;
    end
    check("pre_rst_pc",  32'(PC),         32'h000103);
    check("pre_rst_cnt", 32'(InstrCount), 32'h3);
    #1 Reset = 1'b1;
    #1;
    check("async_rst_pc",      32'(PC),         32'h000100);
    check("async_rst_cnt",     32'(InstrCount), 32'h0);
    check("async_rst_running", 32'(Running),    32'h1);
    @(negedge Clock);
    Reset = 1'b0;

    // Free-run five instructions from the reset vector.
    exp_pc = 24'h000100;
    for (int i = 0; i < 5; i++) begin
      NextPC = exp_pc + 24'h000001;
      check("run_commit", 32'(Commit), 32'h1);
      tick();
      exp_pc = exp_pc + 24'h000001;
    end
    check("run_pc",  32'(PC),         32'h000105);
    check("run_cnt", 32'(InstrCount), 32'h5);

    // HALT opcode: no commit, PC stays, counter frozen.
    Halt   = 1'b1;
    NextPC = 24'h000106;
    #1;
    check("halt_commit_same_cycle", 32'(Commit), 32'h0);
    tick();
    check("halt_pc",      32'(PC),      32'h000105);
    check("halt_running", 32'(Running), 32'h0);
    Halt = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("halted_pc",     32'(PC),         32'h000105);
    check("halted_cnt",    32'(InstrCount), 32'h5);
    check("halted_commit", 32'(Commit),     32'h0);

    // Single-step pulse.
    NextPC  = 24'h000200;
    StepReq = 1'b1;
    tick();
    StepReq = 1'b0;
    check("step_running", 32'(Running), 32'h1);
    check("step_commit",  32'(Commit),  32'h1);
    tick();
    check("step_pc",      32'(PC),         32'h000200);
    check("step_cnt",     32'(InstrCount), 32'h6);
    check("step_back",    32'(Running),    32'h0);
    tick();
    check("step_hold_pc", 32'(PC),         32'h000200);

    // StepReq held for three cycles: STEP, HALTED, STEP.
    StepReq = 1'b1;
    NextPC  = 24'h000300;
    tick();
    check("hold1_commit", 32'(Commit), 32'h1);
    tick();
    check("hold1_pc",      32'(PC),         32'h000300);
    check("hold1_cnt",     32'(InstrCount), 32'h7);
    check("hold1_running", 32'(Running),    32'h0);
    NextPC = 24'h000301;
    tick();
    StepReq = 1'b0;
    check("hold2_commit", 32'(Commit), 32'h1);
    tick();
    check("hold2_pc",  32'(PC),         32'h000301);
    check("hold2_cnt", 32'(InstrCount), 32'h8);
    tick();
    check("hold_end_running", 32'(Running),    32'h0);
    check("hold_end_cnt",     32'(InstrCount), 32'h8);

    // RunReq and StepReq together: RunReq wins, core free-runs.
    RunReq  = 1'b1;
    StepReq = 1'b1;
    NextPC  = 24'h000999;
    tick();
    RunReq  = 1'b0;
    StepReq = 1'b0;
    check("resume_running", 32'(Running), 32'h1);
    check("resume_pc",      32'(PC),      32'h000301);
    NextPC = 24'h000302;
    tick();
    NextPC = 24'h000303;
    tick();
    check("resume_run_pc",   32'(PC),         32'h000303);
    check("resume_run_cnt",  32'(InstrCount), 32'hA);
    check("resume_still_run", 32'(Running),   32'h1);

    // PC wrap of the incrementer.
    NextPC = 24'hFFFFFF;
    tick();
    check("wrap_pc",      32'(PC),         32'hFFFFFF);
    check("wrap_pcplus1", 32'(PCPlus1),    32'h000000);
    check("wrap_cnt_pre", 32'(InstrCount), 32'hB);

    // Drive the retired counter to its maximum, then one more commit.
    NextPC = 24'h000000;
    for (int i = 0; i < 32'hFFFF - 32'hB; i++) tick();
    check("cnt_max", 32'(InstrCount), 32'hFFFF);
    check("cnt_max_commit", 32'(Commit), 32'h1);
    tick();
    check("cnt_wrap", 32'(InstrCount), 32'h0);

    // Reset arriving during a single step.
    Halt = 1'b1;
    tick();
    Halt    = 1'b0;
    StepReq = 1'b1;
    tick();
    StepReq = 1'b0;
    check("midstep_commit", 32'(Commit), 32'h1);
    #1 Reset = 1'b1;
    #1;
    check("midstep_rst_pc",      32'(PC),         32'h000100);
    check("midstep_rst_cnt",     32'(InstrCount), 32'h0);
    check("midstep_rst_running", 32'(Running),    32'h1);
    @(negedge Clock);
    Reset  = 1'b0;
    NextPC = 24'h000555;
    check("post_rst_commit", 32'(Commit), 32'h1);
    tick();
    check("post_rst_pc",  32'(PC),         32'h000555);
    check("post_rst_cnt", 32'(InstrCount), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
